// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - ioctl download sequencer: ROM forwarding, mod/DIP latches, core reset ownership
module rom_load_sequencer #(
  parameter int unsigned RESET_HOLD    = 4096,
  parameter int unsigned ROM_MIN_BYTES = 16384,
  parameter int unsigned NUM_MODS      = 18
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [7:0]          ioctl_index,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic                user_reset,
  output logic                core_reset,
  output logic                rom_wr,
  output logic [15:0]         rom_addr,
  output logic [7:0]          rom_data,
  output logic [7:0]          mod_sel,
  output logic [NUM_MODS-1:0] mod_onehot,
  output logic [63:0]         dsw,
  output logic [16:0]         rom_bytes,
  output logic                load_done,
  output logic                load_err
);

  localparam int unsigned CW = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {WAIT_ROM, LOAD, HOLD, RUN} state_t;

  state_t          state;
  logic            dl_q;
  logic            load_is_mod;
  logic [CW-1:0]   hold_cnt;

  logic dl_start, dl_end;
  logic idx_rom, idx_mod, idx_dip;
  logic rom_hit, rom_short, mod_bad;

  assign dl_start  = ioctl_download & ~dl_q;
  assign dl_end    = ~ioctl_download & dl_q;
  assign idx_rom   = (ioctl_index == 8'd0);
  assign idx_mod   = (ioctl_index == 8'd1);
  assign idx_dip   = (ioctl_index == 8'd254);
  assign rom_hit   = ioctl_wr & idx_rom & (ioctl_addr[24:16] == 9'd0);
  assign rom_short = ({15'd0, rom_bytes} < ROM_MIN_BYTES);
  assign mod_bad   = ({24'd0, mod_sel} >= NUM_MODS);

  // Tracks the download flag even through reset so a reset mid-download
  // cannot manufacture a fresh dl_start afterwards.
  always_ff @(posedge clk_sys) begin
    dl_q <= ioctl_download;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_wr    <= 1'b0;
      rom_addr  <= 16'd0;
      rom_data  <= 8'd0;
      mod_sel   <= 8'd0;
      dsw       <= 64'hFFFF_FFFF_FFFF_FFFF;
      rom_bytes <= 17'd0;
    end else begin
      rom_wr <= rom_hit;
      if (rom_hit) begin
        rom_addr <= ioctl_addr[15:0];
        rom_data <= ioctl_dout;
      end
      // Bytes beyond 64K are not forwarded but still count toward the load size.
      if (dl_start && idx_rom)
        rom_bytes <= 17'd0;
      else if (ioctl_wr && idx_rom && rom_bytes != 17'h1FFFF)
        rom_bytes <= rom_bytes + 17'd1;
      if (ioctl_wr && idx_mod && ioctl_addr == 25'd0)
        mod_sel <= ioctl_dout;
      if (ioctl_wr && idx_dip && ioctl_addr[24:3] == 22'd0)
        dsw[ioctl_addr[2:0]*8 +: 8] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mod_onehot <= NUM_MODS'(1);
    end else begin
      for (int i = 0; i < int'(NUM_MODS); i++)
        mod_onehot[i] <= (mod_sel == 8'(i));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= WAIT_ROM;
      core_reset  <= 1'b1;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      hold_cnt    <= '0;
      load_is_mod <= 1'b0;
    end else begin
      case (state)
        WAIT_ROM: begin
          core_reset <= 1'b1;
          load_done  <= 1'b0;
          if (dl_start && idx_rom) begin
            state       <= LOAD;
            load_is_mod <= 1'b0;
          end
        end
        LOAD: begin
          if (dl_end) begin
            if (!load_is_mod && rom_short) begin
              state    <= WAIT_ROM;
              load_err <= 1'b1;
            end else begin
              state    <= HOLD;
              hold_cnt <= CW'(RESET_HOLD);
              load_err <= mod_bad;
            end
          end
        end
        HOLD: begin
          if (dl_start && idx_rom) begin
            state       <= LOAD;
            load_is_mod <= 1'b0;
          end else if (dl_start && idx_mod) begin
            hold_cnt <= CW'(RESET_HOLD);
          end else if (hold_cnt == CW'(1)) begin
            state      <= RUN;
            core_reset <= user_reset;
            load_done  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - CW'(1);
          end
        end
        RUN: begin
          core_reset <= user_reset;
          if (dl_start && (idx_rom || idx_mod)) begin
            state       <= LOAD;
            load_is_mod <= idx_mod;
            core_reset  <= 1'b1;
            load_done   <= 1'b0;
          end
        end
        default: state <= WAIT_ROM;
      endcase
      if (mod_bad)
        load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb/tb_rom_load_sequencer.sv - directed self-checking bench for rom_load_sequencer
module tb_rom_load_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        user_reset = 1'b0;
  logic        core_reset;
  logic        rom_wr;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  mod_sel;
  logic [17:0] mod_onehot;
  logic [63:0] dsw;
  logic [16:0] rom_bytes;
  logic        load_done;
  logic        load_err;

  rom_load_sequencer dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .user_reset(user_reset), .core_reset(core_reset),
    .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data), .mod_sel(mod_sel),
    .mod_onehot(mod_onehot), .dsw(dsw), .rom_bytes(rom_bytes),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  int rom_wr_seen = 0;

  always @(negedge clk_sys) if (rom_wr === 1'b1) rom_wr_seen++;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [63:0] exp_dsw;
  } dip_vec_t;

  dip_vec_t vecs [10];

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rom_stream(input int n, output int errs);
    errs = 0;
    for (int a = 0; a < n; a++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'(a);
      tick();
      if (!(rom_wr === 1'b1 && rom_addr === 16'(a) && rom_data === 8'(a))) errs++;
    end
    ioctl_wr = 1'b0;
    tick();
    if (rom_wr !== 1'b0) errs++;
  endtask

  task automatic rom_load(input int n, output int errs);
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    rom_stream(n, errs);
    ioctl_download = 1'b0;
  endtask

  // Counts negedges with core_reset high after the download flag drops.
  task automatic hold_len(output int n);
    n = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (core_reset === 1'b1) n++;
      else break;
    end
  endtask

  task automatic mod_load(input logic [7:0] code, input logic [17:0] prev_oh,
                          input logic [17:0] exp_oh, output int n);
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    tick();
    chk("mod_core_reset_rise", core_reset, 1'b1);
    chk("mod_load_done_fall", load_done, 1'b0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd0;
    ioctl_dout = code;
    tick();
    ioctl_wr = 1'b0;
    chk("mod_sel_latched", mod_sel, code);
    chk("mod_onehot_lag", mod_onehot, prev_oh);
    tick();
    chk("mod_onehot", mod_onehot, exp_oh);
    ioctl_download = 1'b0;
    hold_len(n);
  endtask

  initial begin
    int errs, n, seen0, stuck;

    vecs[0] = '{25'd0,     8'h11, 64'hFFFF_FFFF_FFFF_FF11};
    vecs[1] = '{25'd1,     8'h22, 64'hFFFF_FFFF_FFFF_2211};
    vecs[2] = '{25'd2,     8'h33, 64'hFFFF_FFFF_FF33_2211};
    vecs[3] = '{25'd3,     8'h44, 64'hFFFF_FFFF_4433_2211};
    vecs[4] = '{25'd4,     8'h55, 64'hFFFF_FF55_4433_2211};
    vecs[5] = '{25'd5,     8'h66, 64'hFFFF_6655_4433_2211};
    vecs[6] = '{25'd6,     8'h77, 64'hFF77_6655_4433_2211};
    vecs[7] = '{25'd7,     8'h88, 64'h8877_6655_4433_2211};
    vecs[8] = '{25'd8,     8'h99, 64'h8877_6655_4433_2211};
    vecs[9] = '{25'h10000, 8'h00, 64'h8877_6655_4433_2211};

    // Power-up
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("pwr_core_reset", core_reset, 1'b1);
    chk("pwr_load_done", load_done, 1'b0);
    chk("pwr_load_err", load_err, 1'b0);
    chk("pwr_rom_wr_count", rom_wr_seen, 0);
    chk("pwr_mod_onehot", mod_onehot, 18'h00001);
    chk("pwr_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pwr_rom_bytes", rom_bytes, 17'd0);

    // Full ROM load
    rom_load(16384, errs);
    chk("load1_fwd_errs", errs, 0);
    chk("load1_rom_wr_count", rom_wr_seen, 16384);
    chk("load1_rom_bytes", rom_bytes, 17'd16384);
    hold_len(n);
    chk("load1_hold_cycles", n, 4096);
    chk("load1_load_done", load_done, 1'b1);
    chk("load1_load_err", load_err, 1'b0);

    // Short ROM load stays in WAIT_ROM
    rom_load(100, errs);
    chk("short_fwd_errs", errs, 0);
    stuck = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (core_reset !== 1'b1 || load_done !== 1'b0) stuck++;
    end
    chk("short_core_held", stuck, 0);
    chk("short_load_err", load_err, 1'b1);
    chk("short_rom_bytes", rom_bytes, 17'd100);

    rom_load(16384, errs);
    chk("load2_fwd_errs", errs, 0);
    hold_len(n);
    chk("load2_hold_cycles", n, 4096);
    chk("load2_load_err_clr", load_err, 1'b0);
    chk("load2_load_done", load_done, 1'b1);

    // Mod downloads from RUN
    seen0 = rom_wr_seen;
    mod_load(8'h0C, 18'h00001, 18'h01000, n);
    chk("mod0c_hold_cycles", n, 4096);
    chk("mod0c_load_done", load_done, 1'b1);
    chk("mod0c_load_err", load_err, 1'b0);
    mod_load(8'h20, 18'h01000, 18'h00000, n);
    chk("mod20_load_err", load_err, 1'b1);
    chk("mod20_hold_cycles", n, 4096);
    chk("mod20_load_done", load_done, 1'b1);

    // DIP writes in RUN, table driven
    ioctl_index    = 8'd254;
    ioctl_download = 1'b1;
    tick();
    for (int v = 0; v < 10; v++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = vecs[v].addr;
      ioctl_dout = vecs[v].data;
      tick();
      ioctl_wr = 1'b0;
      chk($sformatf("dip%0d_dsw", v), dsw, vecs[v].exp_dsw);
      chk($sformatf("dip%0d_core_reset", v), core_reset, 1'b0);
    end
    ioctl_download = 1'b0;
    tick();
    tick();
    chk("dip_after_core_reset", core_reset, 1'b0);
    chk("dip_after_load_done", load_done, 1'b1);
    chk("nonrom_rom_wr_count", rom_wr_seen - seen0, 0);

    // user_reset passthrough in RUN
    user_reset = 1'b1;
    tick();
    chk("ureset_rise", core_reset, 1'b1);
    chk("ureset_load_done", load_done, 1'b1);
    user_reset = 1'b0;
    tick();
    chk("ureset_fall", core_reset, 1'b0);

    // Reset mid-load, coincident with byte 5000
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    chk("reload_core_reset", core_reset, 1'b1);
    chk("reload_load_done", load_done, 1'b0);
    rom_stream(5000, errs);
    chk("reload_fwd_errs", errs, 0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd5000;
    ioctl_dout = 8'h88;
    reset      = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    reset    = 1'b0;
    chk("rst_wr_dropped", rom_wr, 1'b0);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_rom_bytes", rom_bytes, 17'd0);
    chk("rst_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    ioctl_download = 1'b0;
    stuck = 0;
    for (int i = 0; i < 4500; i++) begin
      tick();
      if (core_reset !== 1'b1 || load_done !== 1'b0) stuck++;
    end
    chk("rst_no_hold", stuck, 0);
    chk("rst_load_err", load_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
